// File: rtl/sc_upcntcmp.sv
// Start/stop controlled up-counter that wraps through a >= compare against a limit bus.
// Define SC_UPCNTCMP_EVENTCNT_EN to add an 8-bit saturating count of terminal ticks.
module sc_upcntcmp #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int ONESHOT       = 0
) (
  input  logic                     SC_UPCNTCMP_CLOCK_50,
  input  logic                     SC_UPCNTCMP_Reset_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] SC_UPCNTCMP_Limit_InBUS,
  input  logic                     SC_UPCNTCMP_Start_InHigh,
  input  logic                     SC_UPCNTCMP_Stop_InHigh,
  input  logic                     SC_UPCNTCMP_Enable_InHigh,
  output logic [DATAWIDTH_BUS-1:0] SC_UPCNTCMP_Count_OutBUS,
  output logic                     SC_UPCNTCMP_Tick_OutHigh,
  output logic                     SC_UPCNTCMP_Busy_OutHigh,
`ifdef SC_UPCNTCMP_EVENTCNT_EN
  output logic [7:0]               SC_UPCNTCMP_EventCount_OutBUS,
`endif
  output logic                     SC_UPCNTCMP_Done_OutHigh
);

  localparam logic [DATAWIDTH_BUS-1:0] COUNT_ONE = {{(DATAWIDTH_BUS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] count_q, count_d;
  logic                     tick_q, tick_d;
  logic                     wrap;

  // The tick follows the wrap even when Stop lands on the same edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap    = (state_q == RUN) && SC_UPCNTCMP_Enable_InHigh &&
              (count_q >= SC_UPCNTCMP_Limit_InBUS);
    tick_d  = wrap;

    if (SC_UPCNTCMP_Stop_InHigh) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          if (SC_UPCNTCMP_Start_InHigh) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (SC_UPCNTCMP_Enable_InHigh) begin
            if (wrap) begin
              count_d = '0;
              if (ONESHOT != 0) begin
                state_d = DONE;
              end
            end else begin
              count_d = count_q + COUNT_ONE;
            end
          end
        end
        DONE: begin
          count_d = '0;
          if (!SC_UPCNTCMP_Start_InHigh) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge SC_UPCNTCMP_CLOCK_50 or posedge SC_UPCNTCMP_Reset_InHigh) begin
    if (SC_UPCNTCMP_Reset_InHigh) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

`ifdef SC_UPCNTCMP_EVENTCNT_EN
  logic [7:0] event_cnt_q, event_cnt_d;

  // A fresh launch from IDLE takes precedence over counting a stale tick.
  always_comb begin
    event_cnt_d = event_cnt_q;
    if ((state_q == IDLE) && (state_d == RUN)) begin
      event_cnt_d = '0;
    end else if (tick_q && (event_cnt_q != 8'hFF)) begin
      event_cnt_d = event_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge SC_UPCNTCMP_CLOCK_50 or posedge SC_UPCNTCMP_Reset_InHigh) begin
    if (SC_UPCNTCMP_Reset_InHigh) begin
      event_cnt_q <= '0;
    end else begin
      event_cnt_q <= event_cnt_d;
    end
  end

  assign SC_UPCNTCMP_EventCount_OutBUS = event_cnt_q;
`endif

  assign SC_UPCNTCMP_Count_OutBUS = count_q;
  assign SC_UPCNTCMP_Tick_OutHigh = tick_q;
  assign SC_UPCNTCMP_Busy_OutHigh = (state_q == RUN);
  assign SC_UPCNTCMP_Done_OutHigh = (state_q == DONE);

endmodule

// File: tb/tb_sc_upcntcmp.sv
// Bench for sc_upcntcmp: a continuous (index 0) and a one-shot (index 1) instance share stimulus.
// Checks SC_UPCNTCMP_EventCount_OutBUS too when SC_UPCNTCMP_EVENTCNT_EN is defined.
module tb_sc_upcntcmp;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] limit = 8'd3;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;

  logic [7:0] count_o [2];
  logic       tick_o [2];
  logic       busy_o [2];
  logic       done_o [2];
`ifdef SC_UPCNTCMP_EVENTCNT_EN
  logic [7:0] events_o [2];
`endif

  int checks = 0;
  int failures = 0;

  int m_count [2];
  bit m_tick [2];
  bit m_busy [2];
  bit m_done [2];
  int m_events [2];

  always #5 clk = ~clk;

  sc_upcntcmp #(.DATAWIDTH_BUS(8), .ONESHOT(0)) u_cont (
    .SC_UPCNTCMP_CLOCK_50         (clk),
    .SC_UPCNTCMP_Reset_InHigh     (rst),
    .SC_UPCNTCMP_Limit_InBUS      (limit),
    .SC_UPCNTCMP_Start_InHigh     (start),
    .SC_UPCNTCMP_Stop_InHigh      (stop),
    .SC_UPCNTCMP_Enable_InHigh    (en),
    .SC_UPCNTCMP_Count_OutBUS     (count_o[0]),
    .SC_UPCNTCMP_Tick_OutHigh     (tick_o[0]),
    .SC_UPCNTCMP_Busy_OutHigh     (busy_o[0]),
`ifdef SC_UPCNTCMP_EVENTCNT_EN
    .SC_UPCNTCMP_EventCount_OutBUS(events_o[0]),
`endif
    .SC_UPCNTCMP_Done_OutHigh     (done_o[0])
  );

  sc_upcntcmp #(.DATAWIDTH_BUS(8), .ONESHOT(1)) u_once (
    .SC_UPCNTCMP_CLOCK_50         (clk),
    .SC_UPCNTCMP_Reset_InHigh     (rst),
    .SC_UPCNTCMP_Limit_InBUS      (limit),
    .SC_UPCNTCMP_Start_InHigh     (start),
    .SC_UPCNTCMP_Stop_InHigh      (stop),
    .SC_UPCNTCMP_Enable_InHigh    (en),
    .SC_UPCNTCMP_Count_OutBUS     (count_o[1]),
    .SC_UPCNTCMP_Tick_OutHigh     (tick_o[1]),
    .SC_UPCNTCMP_Busy_OutHigh     (busy_o[1]),
`ifdef SC_UPCNTCMP_EVENTCNT_EN
    .SC_UPCNTCMP_EventCount_OutBUS(events_o[1]),
`endif
    .SC_UPCNTCMP_Done_OutHigh     (done_o[1])
  );

  // Reference behaviour: busy/done flags plus an integer count, updated from the rules directly.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_count[k] = 0; m_tick[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_events[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit wrap_now;
        bit old_tick;
        bit launch;
        wrap_now = m_busy[k] && en && (m_count[k] >= int'(limit));
        old_tick = m_tick[k];
        launch   = !m_busy[k] && !m_done[k] && start && !stop;
        if (stop) begin
          m_busy[k] = 0; m_done[k] = 0; m_count[k] = 0;
        end else if (m_busy[k]) begin
          if (en) begin
            if (wrap_now) begin
              m_count[k] = 0;
              if (k == 1) begin
                m_busy[k] = 0; m_done[k] = 1;
              end
            end else begin
              m_count[k] = m_count[k] + 1;
            end
          end
        end else if (m_done[k]) begin
          if (!start) m_done[k] = 0;
        end else if (start) begin
          m_busy[k] = 1;
        end
        m_tick[k] = wrap_now;
        if (launch) m_events[k] = 0;
        else if (old_tick && m_events[k] < 255) m_events[k] = m_events[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (count_o[k] !== 8'(m_count[k]) || tick_o[k] !== m_tick[k] ||
          busy_o[k] !== m_busy[k] || done_o[k] !== m_done[k]) begin
        failures++;
        $display("[TB] FAIL model_cmp dut%0d t=%0t actual count=%0d tick=%b busy=%b done=%b required count=%0d tick=%b busy=%b done=%b",
                 k, $time, count_o[k], tick_o[k], busy_o[k], done_o[k],
                 m_count[k], m_tick[k], m_busy[k], m_done[k]);
      end
`ifdef SC_UPCNTCMP_EVENTCNT_EN
      checks++;
      if (events_o[k] !== 8'(m_events[k])) begin
        failures++;
        $display("[TB] FAIL model_events dut%0d t=%0t actual=%0d required=%0d",
                 k, $time, events_o[k], m_events[k]);
      end
`endif
    end
  end

  task automatic applyStimulus(input bit st, input bit sp, input bit e, input int lim);
    @(negedge clk);
    start = st;
    stop  = sp;
    en    = e;
    limit = 8'(lim);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int k, input int c,
                             input bit t, input bit b, input bit d);
    checks++;
    if (count_o[k] !== 8'(c) || tick_o[k] !== t || busy_o[k] !== b || done_o[k] !== d) begin
      failures++;
      $display("[TB] FAIL %s dut%0d actual count=%0d tick=%b busy=%b done=%b required count=%0d tick=%b busy=%b done=%b",
               name, k, count_o[k], tick_o[k], busy_o[k], done_o[k], c, t, b, d);
    end
  endtask

`ifdef SC_UPCNTCMP_EVENTCNT_EN
  task automatic checkEvents(input string name, input int k, input int ev);
    checks++;
    if (events_o[k] !== 8'(ev)) begin
      failures++;
      $display("[TB] FAIL %s dut%0d actual events=%0d required events=%0d", name, k, events_o[k], ev);
    end
  endtask
`endif

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int exp_c [5] = '{1, 2, 3, 0, 1};
    bit exp_t [5] = '{0, 0, 0, 1, 0};
    int seq_c [4] = '{3, 3, 3, 4};
    bit seq_e [4] = '{1, 0, 0, 1};

    rst = 1'b1;
    #2;
    checkOutput("reset_cont", 0, 0, 0, 0, 0);
    checkOutput("reset_once", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] limit 3 continuous count");
    applyStimulus(1, 0, 1, 3);
    checkOutput("start_busy", 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 3);
      checkOutput("cont_seq", 0, exp_c[i], exp_t[i], 1, 0);
      if (i == 3) checkOutput("once_wrap_done", 1, 0, 1, 0, 1);
    end
    applyStimulus(0, 1, 0, 3);
    checkOutput("stop_idle", 0, 0, 0, 0, 0);

    $display("[TB] limit 2 one-shot with held start");
    applyStimulus(1, 0, 1, 2);
    checkOutput("once_start", 1, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 2);
    checkOutput("once_c1", 1, 1, 0, 1, 0);
    applyStimulus(1, 0, 1, 2);
    checkOutput("once_c2", 1, 2, 0, 1, 0);
    applyStimulus(1, 0, 1, 2);
    checkOutput("once_done", 1, 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 2);
    checkOutput("once_hold1", 1, 0, 0, 0, 1);
    applyStimulus(1, 0, 1, 2);
    checkOutput("once_hold2", 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 2);
    checkOutput("once_release", 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 2);

    $display("[TB] enable gating and limit change");
    applyStimulus(1, 0, 0, 5);
    applyStimulus(0, 0, 1, 5);
    applyStimulus(0, 0, 1, 5);
    checkOutput("gate_pre", 0, 2, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, seq_e[i], 5);
      checkOutput("gate_seq", 0, seq_c[i], 0, 1, 0);
    end
    applyStimulus(0, 0, 1, 9);
    applyStimulus(0, 0, 1, 9);
    checkOutput("limit9_c6", 0, 6, 0, 1, 0);
    applyStimulus(0, 0, 1, 4);
    checkOutput("limit_lowered_cont", 0, 0, 1, 1, 0);
    checkOutput("limit_lowered_once", 1, 0, 1, 0, 1);

    $display("[TB] stop priority");
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 9);
    checkOutput("count7", 0, 7, 0, 1, 0);
    applyStimulus(1, 1, 1, 9);
    checkOutput("stop_over_start", 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("stop_wrap_tick_cont", 0, 0, 1, 0, 0);
    checkOutput("stop_wrap_tick_once", 1, 0, 1, 0, 0);

    $display("[TB] limit 0");
    applyStimulus(1, 0, 1, 0);
    checkOutput("lim0_start", 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0);
      checkOutput("lim0_tick", 0, 0, 1, 1, 0);
    end
    applyStimulus(0, 1, 0, 0);

    $display("[TB] async reset mid-count");
    applyStimulus(1, 0, 1, 200);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 200);
    checkOutput("pre_reset_c4", 0, 4, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_cont", 0, 0, 0, 0, 0);
    checkOutput("async_reset_once", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 1, 200);
    applyStimulus(0, 0, 1, 200);
    checkOutput("post_reset_idle", 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 200);
    checkOutput("post_reset_start", 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 200);

    $display("[TB] full range limit 255");
    applyStimulus(1, 0, 1, 255);
    for (int i = 0; i < 255; i++) applyStimulus(0, 0, 1, 255);
    checkOutput("full_c255", 0, 255, 0, 1, 0);
    applyStimulus(0, 0, 1, 255);
    checkOutput("full_wrap", 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 255);

`ifdef SC_UPCNTCMP_EVENTCNT_EN
    $display("[TB] event counter saturation");
    applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 0, 1, 0);
    checkEvents("events_sat", 0, 255);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0);
    checkEvents("events_clear", 0, 0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_upcntcmp.md
SC_UPCNTCMP -- requirements
Module: sc_upcntcmp

Interface
REQ-001 SHALL have parameter DATAWIDTH_BUS, default 8: width of the limit bus and the count.
REQ-002 SHALL have parameter ONESHOT, default 0. 0 = continuous counting; 1 = stop after the first terminal count.
REQ-003 SHALL have port SC_UPCNTCMP_CLOCK_50, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port SC_UPCNTCMP_Reset_InHigh, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port SC_UPCNTCMP_Limit_InBUS, input, DATAWIDTH_BUS bits: terminal value, driven by the upstream fixed register.
REQ-006 SHALL have port SC_UPCNTCMP_Start_InHigh, input, 1 bit: start request (level).
REQ-007 SHALL have port SC_UPCNTCMP_Stop_InHigh, input, 1 bit: abort request (level).
REQ-008 SHALL have port SC_UPCNTCMP_Enable_InHigh, input, 1 bit: count-advance qualifier.
REQ-009 SHALL have port SC_UPCNTCMP_Count_OutBUS, output, DATAWIDTH_BUS bits: current count, registered.
REQ-010 SHALL have port SC_UPCNTCMP_Tick_OutHigh, output, 1 bit: terminal-count pulse, registered.
REQ-011 SHALL have port SC_UPCNTCMP_Busy_OutHigh, output, 1 bit: high in state RUN.
REQ-012 SHALL have port SC_UPCNTCMP_Done_OutHigh, output, 1 bit: high in state DONE.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE; all outputs SHALL be decoded from registers only.
REQ-014 IDLE: the count SHALL be held at 0; Start=1 and Stop=0 SHALL give RUN on the next edge, with the count still 0.
REQ-015 RUN, Enable=1, count < Limit: the count SHALL increment by 1 per edge.
REQ-016 RUN, Enable=1, count >= Limit: the count SHALL load 0, and Tick SHALL be high for exactly the following cycle.
- The >= comparison covers a Limit lowered mid-run below the current count: the count wraps on the next enabled edge.
REQ-017 RUN, Enable=0: the count SHALL hold, Tick SHALL be 0, and the state SHALL be unchanged.
REQ-018 Limit=0: the count SHALL stay 0, and Tick SHALL be high in every cycle following an enabled RUN edge.
REQ-019 ONESHOT=1: the wrap edge SHALL also move RUN to DONE.
REQ-020 ONESHOT=0: the wrap edge SHALL keep the FSM in RUN.
REQ-021 DONE: the count SHALL be 0; the FSM SHALL return to IDLE only on an edge with Start=0 (level handshake), so a held Start SHALL NOT retrigger.
REQ-022 Stop=1 SHALL force IDLE and count 0 on the next edge from any state.
- Stop SHALL have priority over Start, Enable and the wrap condition.
- A wrap coinciding with Stop SHALL still produce its Tick.
REQ-023 Count arithmetic SHALL be unsigned modulo 2^DATAWIDTH_BUS.
- Limit = all-ones SHALL count the full range, and SHALL wrap only through the compare, never by overflow.
REQ-024 Latency: Start to Busy = 1 cycle; final enabled edge to Tick = 1 cycle; wrap to Done = 1 cycle (ONESHOT=1).

Reset
REQ-025 Reset asserted SHALL immediately, without a clock, force state IDLE, Count=0, Tick=0, Busy=0, Done=0 (and EventCount=0 when compiled in).
REQ-026 Reset mid-count SHALL discard the count; after release the block SHALL wait in IDLE for a fresh Start.

Configuration
REQ-027 Macro SC_UPCNTCMP_EVENTCNT_EN defined:
- SHALL add output port SC_UPCNTCMP_EventCount_OutBUS, 8 bits.
- It SHALL increment on every cycle in which Tick is high, and saturate at 255.
- It SHALL clear to 0 on an IDLE-to-RUN transition.
REQ-028 Macro SC_UPCNTCMP_EVENTCNT_EN undefined: the port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Limit=3, ONESHOT=0, Start pulse, Enable=1 -> Count 0,1,2,3,0,1,...; Tick high in each cycle Count=0 after a wrap; Busy=1 from the cycle after Start.
REQ-030 Limit=2, ONESHOT=1, Start held high -> Count 0,1,2, then Done=1 and Count=0; Done stays high while Start=1; IDLE one cycle after Start drops.
REQ-031 Limit=5, Count=2, Enable toggled 1,0,0,1 -> Count 3,3,3,4; no Tick.
REQ-032 Count=6, Limit changed 9->4 -> next enabled edge gives Count=0 and a Tick.
REQ-033 Count=7, Stop and Start both high -> IDLE, Count=0, Busy=0; async reset pulsed mid-count -> all outputs 0 before the next clock edge.
REQ-034 SC_UPCNTCMP_EVENTCNT_EN defined, Limit=0, 300 enabled cycles -> EventCount saturates at 255; a new Start clears it to 0.
